// File: rtl/speaker_pkg.sv
// rtl/speaker_pkg.sv - register map, bit positions and reset values for the speaker sample controller
package speaker_pkg;

    localparam int SAMPLE_W = 8;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_RATE   = 8'h04;
    localparam logic [7:0] ADDR_DATA   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h0C;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STATUS_COUNT_W  = 7;
    localparam int STATUS_FULL     = 8;
    localparam int STATUS_EMPTY    = 9;
    localparam int STATUS_UNDERRUN = 10;
    localparam int STATUS_LWM_LSB  = 16;
    localparam int STATUS_LWM_W    = 7;

    localparam logic [15:0] RATE_MIN   = 16'd256;
    localparam logic [15:0] RATE_RESET = 16'd256;
    localparam logic [STATUS_LWM_W-1:0] LWM_RESET = 7'd4;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_RATE,
        REG_DATA,
        REG_STATUS,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [7:0] addr);
        case (addr)
            ADDR_CTRL:   return REG_CTRL;
            ADDR_RATE:   return REG_RATE;
            ADDR_DATA:   return REG_DATA;
            ADDR_STATUS: return REG_STATUS;
            default:     return REG_NONE;
        endcase
    endfunction

    // Periods shorter than one full PWM cycle are raised to the minimum.
    function automatic logic [15:0] clamp_rate(input logic [15:0] value);
        return (value < RATE_MIN) ? RATE_MIN : value;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - sample FIFO with push, pop and single-cycle flush
// Ports: clk/rst clock and sync active-high reset; push/din write side;
//        pop/dout read side (dout is the head, valid when !empty);
//        flush empties in one cycle; count/full/empty occupancy.
module sample_fifo
    import speaker_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [SAMPLE_W-1:0]       din,
    output logic [SAMPLE_W-1:0]       dout,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic                do_push;
    logic                do_pop;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign dout  = mem[rptr];

    // Flush wins over both sides. A pop in the same cycle frees the slot,
    // so a push is still accepted when full.
    assign do_pop  = pop & ~empty & ~flush & ~rst;
    assign do_push = push & ~flush & ~rst & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/speaker_sample_ctrl.sv
// rtl/speaker_sample_ctrl.sv - APB sample FIFO, sample-rate tick and PWM speaker driver
// Ports: PCLK sole clock; PRESET sync active-high reset;
//        PSEL/PENABLE/PWRITE/PADDR/PWDATA APB3 request; PRDATA/PREADY/PSLVERR APB response;
//        SPEAKER_DAC PWM audio out; FIFO_IRQ level interrupt (low-water or underrun).
module speaker_sample_ctrl
    import speaker_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        SPEAKER_DAC,
    output logic        FIFO_IRQ
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    reg_sel_e                  sel;
    logic                      xfer;
    logic                      wr;
    logic                      ctrl_wr;
    logic                      rate_wr;
    logic                      data_wr;
    logic                      status_wr;
    logic                      en;
    logic                      irq_en;
    logic                      underrun;
    logic                      irq;
    logic [15:0]               rate;
    logic [15:0]               rate_cnt;
    logic [STATUS_LWM_W-1:0]   lwm;
    logic [7:0]                pwm_cnt;
    logic [SAMPLE_W-1:0]       cur_sample;
    logic                      tick;
    logic                      flush;
    logic                      pop_req;
    logic [CW-1:0]             fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [SAMPLE_W-1:0]       fifo_head;
    logic [STATUS_COUNT_W-1:0] count_ext;
    logic [31:0]               status_word;
    logic                      unused_pwdata;

    assign sel       = decode_addr(PADDR);
    assign xfer      = PSEL & PENABLE;
    assign wr        = xfer & PWRITE;
    assign ctrl_wr   = wr && (sel == REG_CTRL);
    assign rate_wr   = wr && (sel == REG_RATE);
    assign data_wr   = wr && (sel == REG_DATA);
    assign status_wr = wr && (sel == REG_STATUS);
    assign flush     = ctrl_wr & PWDATA[CTRL_FLUSH];
    assign tick      = en && (rate_cnt == '0);
    assign pop_req   = tick & ~fifo_empty & ~flush;
    assign count_ext = STATUS_COUNT_W'(fifo_count);

    assign unused_pwdata = ^PWDATA[31:23];

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (data_wr),
        .pop   (pop_req),
        .flush (flush),
        .din   (PWDATA[SAMPLE_W-1:0]),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            en     <= 1'b0;
            irq_en <= 1'b0;
            rate   <= RATE_RESET;
            lwm    <= LWM_RESET;
        end else begin
            if (ctrl_wr) begin
                en     <= PWDATA[CTRL_EN];
                irq_en <= PWDATA[CTRL_IRQ_EN];
            end
            if (rate_wr) begin
                rate <= clamp_rate(PWDATA[15:0]);
            end
            if (status_wr) begin
                lwm <= PWDATA[STATUS_LWM_LSB +: STATUS_LWM_W];
            end
        end
    end

    // Down-counter reloads from the live RATE value only when it hits zero,
    // so a RATE write never disturbs the period in progress.
    always_ff @(posedge PCLK) begin
        if (PRESET || !en) begin
            rate_cnt <= '0;
            pwm_cnt  <= '0;
        end else begin
            rate_cnt <= (rate_cnt == '0) ? rate - 16'd1 : rate_cnt - 16'd1;
            pwm_cnt  <= pwm_cnt + 8'd1;
        end
    end

    // A set from an empty tick outranks a software clear on the same edge.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cur_sample <= '0;
            underrun   <= 1'b0;
        end else begin
            if (pop_req) begin
                cur_sample <= fifo_head;
            end
            if (tick && fifo_empty && !flush) begin
                underrun <= 1'b1;
            end else if (status_wr && PWDATA[STATUS_UNDERRUN]) begin
                underrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en & (underrun | (count_ext <= lwm));
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STATUS_COUNT_W-1:0]              = count_ext;
        status_word[STATUS_FULL]                     = fifo_full;
        status_word[STATUS_EMPTY]                    = fifo_empty;
        status_word[STATUS_UNDERRUN]                 = underrun;
        status_word[STATUS_LWM_LSB +: STATUS_LWM_W]  = lwm;
    end

    always_comb begin
        PRDATA = '0;
        if (xfer && !PWRITE) begin
            case (sel)
                REG_CTRL: begin
                    PRDATA[CTRL_EN]     = en;
                    PRDATA[CTRL_IRQ_EN] = irq_en;
                end
                REG_RATE:   PRDATA[15:0] = rate;
                REG_STATUS: PRDATA       = status_word;
                default:    PRDATA       = '0;
            endcase
        end
    end

    assign PREADY      = 1'b1;
    assign PSLVERR     = data_wr & fifo_full & ~pop_req & ~PRESET;
    assign SPEAKER_DAC = en & (pwm_cnt < cur_sample);
    assign FIFO_IRQ    = irq;

endmodule

// File: doc/speaker_sample_ctrl.md
SPEAKER_SAMPLE_CTRL -- requirements
Module: speaker_sample_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, sample FIFO entries (power of two, 4..64).
REQ-002 SHALL have port PCLK  in  1  sole clock (fabric APB clock); all logic rising-edge.
REQ-003 SHALL have port PRESET  in  1  reset, synchronous, active-high.
REQ-004 SHALL have APB3 slave ports PSEL in 1, PENABLE in 1, PWRITE in 1, PADDR in 8, PWDATA in 32: MSS APB master request.
REQ-005 SHALL have ports PRDATA out 32 (read data), PREADY out 1 (always 1, zero wait states) and PSLVERR out 1 (slave error).
REQ-006 SHALL have port SPEAKER_DAC  out  1  PWM audio output to the speaker.
REQ-007 SHALL have port FIFO_IRQ  out  1  level interrupt: FIFO low-water or underrun.

Function
REQ-008 SHALL treat an APB transfer as PSEL&PENABLE; writes take effect on that edge; PRDATA is combinational during the access phase and zero otherwise.
REQ-009 SHALL map 0x00 CTRL: bit0 EN (R/W), bit1 FLUSH (write-1 pulse, reads 0), bit2 IRQ_EN (R/W).
REQ-010 SHALL map 0x04 RATE: bits[15:0] sample period in PCLK cycles (R/W); written values below 256 are stored as 256.
REQ-011 SHALL map 0x08 DATA: write bits[7:0] pushes one unsigned sample; reads return 0.
REQ-012 SHALL map 0x0C STATUS: [6:0] count, [8] full, [9] empty, [10] UNDERRUN sticky (write 1 to clear), [22:16] low-water threshold LWM (R/W).
REQ-013 SHALL return PRDATA=0 for unmapped addresses; writes to them are ignored without error.
REQ-014 SHALL assert PSLVERR for a DATA write while full; the sample is dropped and count is unchanged.
REQ-015 SHALL run a 16-bit rate counter only while EN=1; it reloads at RATE-1, and a tick fires when it reaches 0.
REQ-016 On tick with FIFO non-empty SHALL pop the head into the current-sample register (visible on the next cycle); on tick with FIFO empty SHALL hold the last sample and set UNDERRUN.
REQ-017 SHALL run an 8-bit free-running PWM counter while EN=1; SPEAKER_DAC = (pwm_cnt < cur_sample), so sample 0 gives constant 0 and sample 255 gives 255/256 duty.
REQ-018 SHALL drive SPEAKER_DAC=0 and hold both counters at 0 while EN=0; FIFO contents are retained.
REQ-019 A push and a pop in the same cycle SHALL leave count unchanged; this applies even when full (the pop frees the slot and no PSLVERR is raised) and when empty is not true.
REQ-020 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-021 FLUSH SHALL empty the FIFO in one cycle, take priority over a simultaneous push or pop, and leave cur_sample and UNDERRUN unchanged.
REQ-022 SHALL drive FIFO_IRQ = IRQ_EN & (UNDERRUN | count <= LWM), registered with one cycle latency.
REQ-023 A RATE write SHALL take effect at the next reload; the counter in progress is not restarted.

Reset
REQ-024 PRESET SHALL, mid-operation, abort any pending pop or push and force: EN=0, IRQ_EN=0, RATE=256, LWM=4, FIFO empty, cur_sample=0, UNDERRUN=0, both counters 0, SPEAKER_DAC=0, FIFO_IRQ=0, PSLVERR=0.

Structure
REQ-025 Register offsets, CTRL/STATUS bit positions and reset values SHALL live in a shared package, speaker_pkg.
REQ-026 The FIFO SHALL be a sub-module, sample_fifo (push, pop, flush, count, full, empty); the APB decode, rate tick and PWM logic SHALL stay in the top level.

Verification
REQ-027 Reset, then read all registers -> CTRL=0, RATE=0x100, STATUS=0x00040200.
REQ-028 Push 16 samples, then a 17th -> 17th write has PSLVERR=1; STATUS count=16 with full=1.
REQ-029 RATE=256, push 0x80, EN=1 -> after the first tick, SPEAKER_DAC is high for 128 of every 256 cycles.
REQ-030 EN=1 with the FIFO empty, IRQ_EN=1 -> UNDERRUN=1 after the first tick, FIFO_IRQ=1 one cycle later; write 0x400 to STATUS -> FIFO_IRQ drops (if count > LWM).
REQ-031 FIFO full, DATA write on the same cycle as a tick -> no PSLVERR, count stays 16, popped order is preserved.
REQ-032 Assert PRESET while 8 samples are queued and EN=1 -> next cycle: count=0, SPEAKER_DAC=0, EN=0.
